// File: rtl/bsg_rocket_pkg.sv
`default_nettype none
// bsg_host link packet type plus default sizing for the host-side endpoint.
package bsg_rocket_pkg;

  localparam int bsg_host_width_p = 48;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] addr;
    logic [31:0] data;
  } bsg_host_t;

  localparam int bsg_host_endpoint_credits_gp = 4;
  localparam int bsg_host_endpoint_timeout_gp = 1024;

endpackage
`default_nettype wire

// File: rtl/bsg_host_resp_fifo.sv
`default_nettype none
// Two-entry response buffer: valid/ready on the way in, valid/yumi on the way out.
module bsg_host_resp_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic [1:0]         count_next;
  logic               ready;
  logic               enq;
  logic               deq;

  assign enq = v_i & ready;
  assign deq = yumi_i & (count != 2'd0);

  always_comb begin
    count_next = count;
    if (enq & ~deq)
      count_next = count + 2'd1;
    else if (deq & ~enq)
      count_next = count - 2'd1;
  end

  // Ready is registered from the next occupancy so the link never sees a comb path.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++)
        mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      ready  <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq)
        rd_ptr <= ~rd_ptr;
      count <= count_next;
      ready <= (count_next != 2'd2);
    end
  end

  assign ready_o = ready;
  assign v_o     = (count != 2'd0);
  assign data_o  = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/bsg_host_endpoint.sv
`default_nettype none
// Host-side bsg_host endpoint: credit-limited request register toward the bridge,
// buffered response return, outstanding tracking, error and timeout flags.
module bsg_host_endpoint
  import bsg_rocket_pkg::*;
#(
  parameter int credits_p = bsg_host_endpoint_credits_gp,
  parameter int timeout_p = bsg_host_endpoint_timeout_gp
) (
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      cmd_v_i,
  input  bsg_host_t cmd_data_i,
  output logic      cmd_ready_o,
  output logic      host_valid_o,
  output bsg_host_t host_data_o,
  input  logic      host_ready_i,
  input  logic      host_valid_i,
  input  bsg_host_t host_data_i,
  output logic      host_ready_o,
  output logic      resp_v_o,
  output bsg_host_t resp_data_o,
  input  logic      resp_yumi_i,
  output logic [3:0] outstanding_o,
  output logic      error_o,
  output logic      timeout_o,
  input  logic      clear_i
);

  localparam int timer_width = $clog2(timeout_p + 1);
  localparam logic [3:0]             credit_limit  = 4'(credits_p);
  localparam logic [timer_width-1:0] timeout_limit = timer_width'(timeout_p);

  logic                   out_v;
  bsg_host_t              out_data;
  logic [3:0]             outstanding;
  logic [timer_width-1:0] timer;
  logic                   error_flag;
  logic                   timeout_flag;

  logic cmd_ready;
  logic cmd_accept;
  logic has_outstanding;
  logic resp_hs;
  logic resp_enq;
  logic resp_drop;
  logic fifo_ready;

  assign cmd_ready       = reset_n_i & (~out_v | host_ready_i) & (outstanding < credit_limit);
  assign cmd_accept      = cmd_v_i & cmd_ready;
  assign has_outstanding = (outstanding != 4'd0);
  assign resp_hs         = host_valid_i & fifo_ready;
  assign resp_enq        = resp_hs & has_outstanding;
  assign resp_drop       = resp_hs & ~has_outstanding;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v    <= 1'b0;
      out_data <= '0;
    end else if (cmd_accept) begin
      out_v    <= 1'b1;
      out_data <= cmd_data_i;
    end else if (host_ready_i & out_v) begin
      out_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      outstanding <= 4'd0;
    end else begin
      case ({cmd_accept, resp_enq})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Timer only runs while something is in flight and the link stays quiet.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer        <= '0;
      timeout_flag <= 1'b0;
      error_flag   <= 1'b0;
    end else begin
      if (!has_outstanding || resp_hs)
        timer <= '0;
      else if (timer != timeout_limit)
        timer <= timer + 1'b1;
      timeout_flag <= (timer == timeout_limit) | (timeout_flag & ~clear_i);
      error_flag   <= resp_drop | (error_flag & ~clear_i);
    end
  end

  bsg_host_resp_fifo #(
    .width_p ($bits(bsg_host_t))
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (host_valid_i & has_outstanding),
    .data_i    (host_data_i),
    .ready_o   (fifo_ready),
    .v_o       (resp_v_o),
    .data_o    (resp_data_o),
    .yumi_i    (resp_yumi_i)
  );

  assign cmd_ready_o   = cmd_ready;
  assign host_valid_o  = out_v;
  assign host_data_o   = out_data;
  assign host_ready_o  = fifo_ready;
  assign outstanding_o = outstanding;
  assign error_o       = error_flag;
  assign timeout_o     = timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_bsg_host_endpoint.sv
`default_nettype none
// Self-checking bench for bsg_host_endpoint: directed scenarios plus random traffic vs a queue model.
module tb_bsg_host_endpoint;
  import bsg_rocket_pkg::*;

  localparam int CREDITS = 4;
  localparam int TIMEOUT = 8;
  localparam int W       = $bits(bsg_host_t);
  typedef logic [W-1:0] pkt_t;

  logic       clk = 1'b0;
  logic       reset_n_i;
  logic       cmd_v_i, cmd_ready_o;
  pkt_t       cmd_data_i;
  logic       host_valid_o, host_ready_i;
  bsg_host_t  host_data_o;
  logic       host_valid_i, host_ready_o;
  pkt_t       host_data_i;
  logic       resp_v_o, resp_yumi_i;
  bsg_host_t  resp_data_o;
  logic [3:0] outstanding_o;
  logic       error_o, timeout_o, clear_i;

  always #5 clk = ~clk;

  bsg_host_endpoint #(.credits_p(CREDITS), .timeout_p(TIMEOUT)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_data_i    (cmd_data_i),
    .cmd_ready_o   (cmd_ready_o),
    .host_valid_o  (host_valid_o),
    .host_data_o   (host_data_o),
    .host_ready_i  (host_ready_i),
    .host_valid_i  (host_valid_i),
    .host_data_i   (host_data_i),
    .host_ready_o  (host_ready_o),
    .resp_v_o      (resp_v_o),
    .resp_data_o   (resp_data_o),
    .resp_yumi_i   (resp_yumi_i),
    .outstanding_o (outstanding_o),
    .error_o       (error_o),
    .timeout_o     (timeout_o),
    .clear_i       (clear_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending request, credit count, response queue, flags.
  logic m_out_v;
  pkt_t m_out_data;
  int   m_outst;
  pkt_t m_q[$];
  logic m_ready;
  int   m_tcnt;
  logic m_err, m_tmo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic pkt_t rnd_pkt();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic model_reset();
    m_out_v = 1'b0; m_out_data = '0; m_outst = 0; m_q.delete();
    m_ready = 1'b0; m_tcnt = 0; m_err = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic compare_model();
    check("host_valid", 64'(host_valid_o), 64'(m_out_v));
    check("host_data", 64'(host_data_o), 64'(m_out_data));
    check("host_ready", 64'(host_ready_o), 64'(m_ready));
    check("resp_v", 64'(resp_v_o), 64'(m_q.size() > 0));
    if (m_q.size() > 0) check("resp_data", 64'(resp_data_o), 64'(m_q[0]));
    check("outstanding", 64'(outstanding_o), 64'(m_outst));
    check("error", 64'(error_o), 64'(m_err));
    check("timeout", 64'(timeout_o), 64'(m_tmo));
  endtask

  // Called at a falling edge; drives one cycle of inputs, steps the model, returns at the next falling edge.
  task automatic cycle(input logic cv, input pkt_t cd, input logic hr, input logic hv,
                       input pkt_t hd, input logic yu, input logic cl);
    logic rdy, acc, hs, enq, drop, deq;
    int   old_outst;
    cmd_v_i = cv; cmd_data_i = cd; host_ready_i = hr;
    host_valid_i = hv; host_data_i = hd; clear_i = cl;
    resp_yumi_i = yu && (m_q.size() > 0);
    rdy = (!m_out_v || hr) && (m_outst < CREDITS);
    #1 check("cmd_ready", 64'(cmd_ready_o), 64'(rdy));
    acc  = cv && rdy;
    hs   = hv && m_ready;
    enq  = hs && (m_outst > 0);
    drop = hs && (m_outst == 0);
    deq  = resp_yumi_i;
    @(posedge clk);
    old_outst = m_outst;
    if (acc) begin m_out_v = 1'b1; m_out_data = cd; end
    else if (hr) m_out_v = 1'b0;
    m_outst = m_outst + (acc ? 1 : 0) - (enq ? 1 : 0);
    if (deq) void'(m_q.pop_front());
    if (enq) m_q.push_back(hd);
    m_ready = (m_q.size() < 2);
    m_tmo = (m_tcnt == TIMEOUT) || (m_tmo && !cl);
    m_err = drop || (m_err && !cl);
    if (old_outst == 0 || hs) m_tcnt = 0;
    else if (m_tcnt < TIMEOUT) m_tcnt++;
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(input logic hr);
    cycle(1'b0, '0, hr, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_host_valid", 64'(host_valid_o), 64'd0);
    check("rst_host_data", 64'(host_data_o), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    check("rst_host_ready", 64'(host_ready_o), 64'd0);
    check("rst_resp_v", 64'(resp_v_o), 64'd0);
    check("rst_resp_data", 64'(resp_data_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    cmd_v_i = 1'b0; host_valid_i = 1'b0; resp_yumi_i = 1'b0; clear_i = 1'b0; host_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n_i = 1'b1;
    #1 check("rel_host_ready", 64'(host_ready_o), 64'd0);
    idle(1'b1);
    check("rel_host_ready_edge", 64'(host_ready_o), 64'd1);
  endtask

  // Returns every credit, empties the buffer and clears the sticky flags.
  task automatic drain();
    for (int i = 0; i < 40 && (m_outst > 0 || m_q.size() > 0 || m_out_v); i++)
      cycle(1'b0, '0, 1'b1, m_outst > 0, rnd_pkt(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("drain_outstanding", 64'(outstanding_o), 64'd0);
    check("drain_resp_v", 64'(resp_v_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    pkt_t r1, r2, r3;
    reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_data_i = '0; host_ready_i = 1'b0;
    host_valid_i = 1'b0; host_data_i = '0; resp_yumi_i = 1'b0; clear_i = 1'b0;
    model_reset();
    @(negedge clk);
    async_reset();

    // Single transaction
    cycle(1'b1, pkt_t'(16'h1234), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("single_host_valid", 64'(host_valid_o), 64'd1);
    check("single_host_data", 64'(host_data_o), 64'h1234);
    check("single_outstanding", 64'(outstanding_o), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b1, pkt_t'(16'h5678), 1'b0, 1'b0);
    check("single_resp_v", 64'(resp_v_o), 64'd1);
    check("single_resp_data", 64'(resp_data_o), 64'h5678);
    check("single_outstanding_ret", 64'(outstanding_o), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("single_resp_taken", 64'(resp_v_o), 64'd0);

    // Credit limit
    for (int i = 0; i < 6; i++) cycle(1'b1, pkt_t'(i + 16'h100), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("credit_outstanding", 64'(outstanding_o), 64'd4);
    check("credit_cmd_ready", 64'(cmd_ready_o), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b1, rnd_pkt(), 1'b0, 1'b0);
    check("credit_return_ready", 64'(cmd_ready_o), 64'd1);
    cycle(1'b1, pkt_t'(16'h105), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("credit_fifth", 64'(outstanding_o), 64'd4);
    check("credit_fifth_data", 64'(host_data_o), 64'h105);
    drain();

    // Backpressure on the request link
    cycle(1'b1, pkt_t'(16'hAAAA), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rnd_pkt(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("bp_host_data", 64'(host_data_o), 64'hAAAA);
      check("bp_cmd_ready", 64'(cmd_ready_o), 64'd0);
    end
    cycle(1'b1, pkt_t'(16'hBBBB), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, pkt_t'(16'hCCCC), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("bp_outstanding3", 64'(outstanding_o), 64'd3);
    r1 = rnd_pkt(); r2 = rnd_pkt(); r3 = rnd_pkt();
    cycle(1'b0, '0, 1'b1, 1'b1, r1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, r2, 1'b0, 1'b0);
    check("bp_fifo_full", 64'(host_ready_o), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b1, r3, 1'b0, 1'b0);
    check("bp_third_held", 64'(outstanding_o), 64'd1);
    check("bp_head", 64'(resp_data_o), 64'(r1));
    cycle(1'b0, '0, 1'b1, 1'b1, r3, 1'b1, 1'b0);
    check("bp_ready_back", 64'(host_ready_o), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b1, r3, 1'b0, 1'b0);
    check("bp_third_taken", 64'(outstanding_o), 64'd0);
    drain();

    // Spurious response
    cycle(1'b0, '0, 1'b1, 1'b1, rnd_pkt(), 1'b0, 1'b0);
    check("spur_resp_v", 64'(resp_v_o), 64'd0);
    check("spur_error", 64'(error_o), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("spur_clear", 64'(error_o), 64'd0);

    // Timeout
    cycle(1'b1, rnd_pkt(), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (TIMEOUT) idle(1'b1);
    check("tmo_not_yet", 64'(timeout_o), 64'd0);
    idle(1'b1);
    check("tmo_set", 64'(timeout_o), 64'd1);
    repeat (3) idle(1'b1);
    check("tmo_sticky", 64'(timeout_o), 64'd1);
    cycle(1'b0, '0, 1'b1, 1'b1, pkt_t'(16'h7777), 1'b0, 1'b0);
    check("tmo_late_resp", 64'(resp_data_o), 64'h7777);
    check("tmo_late_outst", 64'(outstanding_o), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("tmo_clear", 64'(timeout_o), 64'd0);

    // Async reset with traffic in flight
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_pkt(), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, rnd_pkt(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, rnd_pkt(), 1'b0, 1'b0);
    cycle(1'b1, rnd_pkt(), 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("ar_outstanding", 64'(outstanding_o), 64'd3);
    check("ar_fifo_full", 64'(host_ready_o), 64'd0);
    async_reset();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      cycle($urandom_range(0, 1) == 1, rnd_pkt(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, rnd_pkt(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
